// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  localparam int DEF_AW           = 32;
  localparam int DEF_DW           = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  // Width of the fetch starvation counter; limits up to 15 fit.
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requesters, plus the next value
// of the fetch starvation counter. Purely combinational; the caller decides
// when the result is committed (only on an IDLE arbitration).
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                any_req,
  output arb_owner_t          winner,
  output logic [STARVE_W-1:0] starve_cnt_nxt
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic under_limit;
  logic dm_first;

  // Data has priority until fetch has lost LIMIT contested rounds; a lone
  // data request always wins since there is no fetch to protect.
  always_comb begin
    under_limit    = (starve_cnt < LIMIT);
    dm_first       = dm_req && (under_limit || !if_req);
    any_req        = if_req || dm_req;
    winner         = dm_first ? OWN_DM : OWN_IF;
    starve_cnt_nxt = starve_cnt;
    if (dm_first) begin
      if (if_req && under_limit) begin
        starve_cnt_nxt = starve_cnt + STARVE_W'(1);
      end
    end else if (if_req) begin
      starve_cnt_nxt = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage.
// One transaction in flight; data has priority, fetch is protected from
// starvation. Request side-band is latched at arbitration so the memory
// sees stable, registered command outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_rvalid_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  arb_state_t          state;
  arb_owner_t          owner;
  logic                req_q;
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic [STARVE_W-1:0] starve_cnt;

  logic                any_req;
  arb_owner_t          winner;
  logic [STARVE_W-1:0] starve_cnt_nxt;

  logic                resp_fire;
  logic [DW-1:0]       resp_data;

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .if_req         (if_req_i),
    .dm_req         (dm_req_i),
    .starve_cnt     (starve_cnt),
    .any_req        (any_req),
    .winner         (winner),
    .starve_cnt_nxt (starve_cnt_nxt)
  );

  // Transaction FSM: arbitrate and latch in IDLE, hold the request until
  // granted, then wait for the single response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            owner      <= winner;
            starve_cnt <= starve_cnt_nxt;
            req_q      <= 1'b1;
            state      <= ARB_REQ;
            if (winner == OWN_DM) begin
              we_q    <= dm_we_i;
              addr_q  <= dm_addr_i;
              wdata_q <= dm_wdata_i;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= if_addr_i;
              wdata_q <= '0;
            end
          end
        end
        ARB_REQ: begin
          // A response arriving before the grant is not ours; ignore it.
          if (mem_gnt_i) begin
            req_q <= 1'b0;
            state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (mem_rvalid_i) begin
            state <= ARB_IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Route the memory response to the latched owner; writes return zero data.
  always_comb begin
    resp_fire   = (state == ARB_RESP) && mem_rvalid_i;
    resp_data   = we_q ? '0 : mem_rdata_i;
    if_rvalid_o = resp_fire && (owner == OWN_IF);
    dm_rvalid_o = resp_fire && (owner == OWN_DM);
    if_rdata_o  = if_rvalid_o ? resp_data : '0;
    dm_rdata_o  = dm_rvalid_o ? resp_data : '0;
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state != ARB_IDLE);

endmodule
